// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//   Shares one shift-add multiplier between N_REQ requesters. A round-robin
//   arbiter picks a requester and latches its operands into mult_a/mult_b. The
//   block then pulses mult_start and waits for mult_ready. It hands the product
//   back to the winner as result, together with a one-cycle done pulse.
//
//   Job timeline (cycle 0 = the IDLE cycle in which the grant is made):
//     0 IDLE -> 1 START -> 2..WIDTH+2 RUN -> WIDTH+3 DONE -> IDLE
//
// Ports
//   clock, n_reset  rising-edge clock, asynchronous active-low reset
//   req             per-requester request, held with stable operands until done
//   a_in, b_in      packed operands, requester i at [i*WIDTH +: WIDTH]
//   done            one-cycle completion pulse to the granted requester
//   result          product of the last completed job, held until the next one
//   grant_id        index of the current or last granted requester
//   busy            high in START, RUN and DONE
//   mult_start      start pulse to the multiplier sequencer
//   mult_a, mult_b  latched operands to the multiplier datapath
//   mult_ready      sequencer ready; product is valid while it is high
//   mult_product    datapath product
// -----------------------------------------------------------------------------
module mult_arbiter #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 4
) (
  input  logic                       clock,
  input  logic                       n_reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     a_in,
  input  logic [N_REQ*WIDTH-1:0]     b_in,
  output logic [N_REQ-1:0]           done,
  output logic [2*WIDTH-1:0]         result,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       mult_start,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic                       mult_ready,
  input  logic [2*WIDTH-1:0]         mult_product
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               mask_q, mask_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  // Arbitration results
  logic [N_REQ-1:0]   req_eff;
  logic               win_found;
  logic [IDW-1:0]     win_id;
  logic [IDW:0]       cand;

  // Round-robin search: first eligible request strictly after the pointer,
  // wrapping modulo N_REQ. One extra bit on cand keeps ptr+k from overflowing.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    req_eff   = req;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    // The just-serviced requester gets one IDLE cycle to drop its request.
    if (mask_q) begin
      req_eff[grant_q] = 1'b0;
    end
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) begin
        cand = cand - (IDW+1)'(N_REQ);
      end
      if (!win_found && req_eff[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    mask_d   = mask_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        // The mask lives for exactly one IDLE cycle, grant or no grant.
        mask_d = 1'b0;
        if (win_found) begin
          grant_d = win_id;
          a_d     = a_in[win_id*WIDTH +: WIDTH];
          b_d     = b_in[win_id*WIDTH +: WIDTH];
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (mult_ready) begin
          result_d = mult_product;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = grant_q;
        mask_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      ptr_q    <= IDW'(N_REQ - 1);
      mask_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      mask_q   <= mask_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Outputs decode from registers only, so no input reaches an output
  // combinationally.
  always_comb begin
    done = '0;
    if (state_q == S_DONE) begin
      done[grant_q] = 1'b1;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign mult_start = (state_q == S_START);
  assign mult_a     = a_q;
  assign mult_b     = b_q;
  assign result     = result_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//   Self-checking bench for mult_arbiter (N_REQ=2, WIDTH=4). It contains a
//   behavioural multiplier sequencer, a job-level reference model that is
//   compared against the DUT on every falling edge, and directed scenarios
//   with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

  localparam int N_REQ = 2;
  localparam int WIDTH = 4;
  localparam int LAT   = WIDTH + 3;   // grant cycle to done cycle

  logic                   clock = 1'b0;
  logic                   n_reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       done;
  logic [2*WIDTH-1:0]     result;
  logic [0:0]             grant_id;
  logic                   busy;
  logic                   mult_start;
  logic [WIDTH-1:0]       mult_a;
  logic [WIDTH-1:0]       mult_b;
  logic                   mult_ready;
  logic [2*WIDTH-1:0]     mult_product;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  mult_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clock        (clock),
    .n_reset      (n_reset),
    .req          (req),
    .a_in         (a_in),
    .b_in         (b_in),
    .done         (done),
    .result       (result),
    .grant_id     (grant_id),
    .busy         (busy),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_ready   (mult_ready),
    .mult_product (mult_product)
  );

  // Sequencer stand-in: WIDTH busy cycles after start, then ready with the
  // product of the operands captured at start. Garbage is shown while busy.
  int               seq_cnt;
  logic [WIDTH-1:0] seq_a, seq_b;

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      seq_cnt <= 0;
      seq_a   <= '0;
      seq_b   <= '0;
    end else if (mult_start) begin
      seq_cnt <= WIDTH;
      seq_a   <= mult_a;
      seq_b   <= mult_b;
    end else if (seq_cnt != 0) begin
      seq_cnt <= seq_cnt - 1;
    end
  end

  assign mult_ready   = (seq_cnt == 0);
  assign mult_product = mult_ready ? ({4'b0, seq_a} * {4'b0, seq_b}) : 8'hA5;

  // Reference model: tracks one job by its age in cycles since grant.
  bit               m_active;
  int               m_t;
  int               m_who;
  int               m_ptr;
  int               m_grant;
  bit               m_mask;
  logic [WIDTH-1:0] m_pa, m_pb;
  logic [7:0]       m_result;

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      m_active = 1'b0;
      m_t      = 0;
      m_who    = 0;
      m_ptr    = N_REQ - 1;
      m_grant  = 0;
      m_mask   = 1'b0;
      m_pa     = '0;
      m_pb     = '0;
      m_result = '0;
    end else if (m_active) begin
      if (m_t == LAT) begin
        m_active = 1'b0;
        m_ptr    = m_who;
        m_mask   = 1'b1;
      end else begin
        m_t = m_t + 1;
        if (m_t == LAT) m_result = {4'b0, m_pa} * {4'b0, m_pb};
      end
    end else begin
      int pick;
      pick = -1;
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (m_ptr + k) % N_REQ;
        if (pick < 0 && req[c] == 1'b1 && !(m_mask && c == m_grant)) pick = c;
      end
      m_mask = 1'b0;
      if (pick >= 0) begin
        m_active = 1'b1;
        m_t      = 1;
        m_who    = pick;
        m_grant  = pick;
        m_pa     = a_in[pick*WIDTH +: WIDTH];
        m_pb     = b_in[pick*WIDTH +: WIDTH];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en && n_reset) begin
      check("m_done", 32'(done), (m_active && m_t == LAT) ? (32'd1 << m_who) : 32'd0);
      check("m_busy", 32'(busy), 32'(m_active));
      check("m_start", 32'(mult_start), 32'(m_active && m_t == 1));
      check("m_result", 32'(result), 32'(m_result));
      check("m_grant", 32'(grant_id), 32'(m_grant));
      check("m_a", 32'(mult_a), 32'(m_pa));
      check("m_b", 32'(mult_b), 32'(m_pb));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got=no pulse want=pulse within 40 cycles at %0t", $time);
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    #2 n_reset = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  task automatic set_ops(input int a0, input int b0, input int a1, input int b1);
    a_in = {4'(a1), 4'(a0)};
    b_in = {4'(b1), 4'(b0)};
  endtask

  initial begin
    bit ok;
    n_reset = 1'b0;
    req     = '0;
    a_in    = '0;
    b_in    = '0;

    // Reset state
    #12;
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(mult_start), 32'd0);
    check("rst_a", 32'(mult_a), 32'd0);
    check("rst_b", 32'(mult_b), 32'd0);
    @(negedge clock);
    n_reset = 1'b1;
    cmp_en  = 1'b1;

    // 1: single job, exact latency
    @(negedge clock);
    set_ops(3, 5, 0, 0);
    req = 2'b01;
    check("t1_busy_c0", 32'(busy), 32'd0);
    cyc(1);
    check("t1_start_c1", 32'(mult_start), 32'd1);
    check("t1_a_c1", 32'(mult_a), 32'd3);
    check("t1_b_c1", 32'(mult_b), 32'd5);
    cyc(6);
    check("t1_done_c7", 32'(done), 32'd1);
    check("t1_result_c7", 32'(result), 32'd15);
    req = 2'b00;
    cyc(1);
    check("t1_busy_c8", 32'(busy), 32'd0);
    check("t1_done_c8", 32'(done), 32'd0);

    // 2: both requesting continuously, fresh pointer -> 0,1,0,1
    reset_dut();
    @(negedge clock);
    set_ops(2, 7, 9, 11);
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_done(ok);
      if (ok) begin
        check("t2_done", 32'(done), (j % 2 == 0) ? 32'd1 : 32'd2);
        check("t2_grant", 32'(grant_id), 32'(j % 2));
        check("t2_result", 32'(result), (j % 2 == 0) ? 32'd14 : 32'd99);
      end
    end
    req = 2'b00;
    cyc(2);

    // 3: arithmetic boundaries
    set_ops(0, 9, 0, 0);
    req = 2'b01;
    wait_done(ok);
    check("t3_zero", 32'(result), 32'd0);
    req = 2'b00;
    cyc(2);
    set_ops(15, 15, 0, 0);
    req = 2'b01;
    wait_done(ok);
    check("t3_max", 32'(result), 32'd225);
    req = 2'b00;
    cyc(2);

    // 4: reset during RUN, then restart with requester 0 first
    set_ops(0, 0, 6, 7);
    req = 2'b10;
    cyc(4);
    check("t4_busy_c4", 32'(busy), 32'd1);
    check("t4_grant_c4", 32'(grant_id), 32'd1);
    check("t4_result_c4", 32'(result), 32'd225);
    #2 n_reset = 1'b0;
    #1;
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_result", 32'(result), 32'd0);
    check("t4_rst_grant", 32'(grant_id), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_start", 32'(mult_start), 32'd0);
    check("t4_rst_a", 32'(mult_a), 32'd0);
    req = 2'b00;
    cyc(1);
    check("t4_hold_done", 32'(done), 32'd0);
    @(negedge clock);
    n_reset = 1'b1;
    set_ops(4, 13, 6, 7);
    req = 2'b11;
    wait_done(ok);
    check("t4_restart_done", 32'(done), 32'd1);
    check("t4_restart_result", 32'(result), 32'd52);
    req = 2'b00;
    cyc(2);

    // 5: req0 dropped in RUN, operands changed after grant, req1 pending
    set_ops(5, 9, 3, 3);
    req = 2'b01;
    cyc(1);
    req = 2'b11;
    set_ops(1, 1, 3, 3);
    cyc(2);
    req = 2'b10;
    cyc(4);
    check("t5_done0", 32'(done), 32'd1);
    check("t5_result0", 32'(result), 32'd45);
    cyc(2);
    check("t5_start1", 32'(mult_start), 32'd1);
    check("t5_grant1", 32'(grant_id), 32'd1);
    check("t5_a1", 32'(mult_a), 32'd3);
    wait_done(ok);
    check("t5_done1", 32'(done), 32'd2);
    check("t5_result1", 32'(result), 32'd9);
    req = 2'b00;
    cyc(2);

    // 6: requester 0 holds req past done; masked for one cycle only
    set_ops(7, 3, 0, 0);
    req = 2'b01;
    wait_done(ok);
    check("t6_done", 32'(done), 32'd1);
    check("t6_result", 32'(result), 32'd21);
    cyc(1);
    check("t6_masked_busy", 32'(busy), 32'd0);
    cyc(1);
    check("t6_c9_busy", 32'(busy), 32'd0);
    check("t6_c9_start", 32'(mult_start), 32'd0);
    cyc(1);
    check("t6_regrant_start", 32'(mult_start), 32'd1);
    check("t6_regrant_busy", 32'(busy), 32'd1);
    wait_done(ok);
    check("t6_done2", 32'(done), 32'd1);
    req = 2'b00;
    cyc(3);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
